// File: rtl/mem_access_unit_if.sv
// Bus bundle between the MEM-stage pipeline, the access unit and data memory.
// The unit takes the slave view; the pipeline/memory side takes the master view.
interface mem_access_unit_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              req_valid;
  logic              req_ready;
  logic              req_store;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_store, req_addr, req_wdata, resp_ready, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_read, mem_write, mem_address, mem_wdata
  );

  modport master (
    output req_valid, req_store, req_addr, req_wdata, resp_ready, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_read, mem_write, mem_address, mem_wdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store initiator: one request at a time, single-cycle memory strobe,
// registered response with bounds checking and access statistics.
module mem_access_unit #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int MEM_DEPTH = 256,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_access_unit_if.slave  bus,
  output logic              busy,
  output logic [CNT_W-1:0]  load_count,
  output logic [CNT_W-1:0]  store_count,
  output logic [CNT_W-1:0]  err_count
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  // One extra bit so MEM_DEPTH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] DEPTH_LIMIT = (ADDR_W + 1)'(MEM_DEPTH);

  state_t            state, state_next;
  logic              accept;
  logic              out_of_range;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  assign accept       = (state == IDLE) && bus.req_valid;
  assign out_of_range = {1'b0, bus.req_addr} >= DEPTH_LIMIT;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (out_of_range)       state_next = RESP;
          else if (bus.req_store) state_next = WRITE;
          else                    state_next = READ;
        end
      end
      READ:    state_next = RESP;
      WRITE:   state_next = RESP;
      RESP:    if (bus.resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Strobes come straight from the state register so they drop with reset.
  always_comb begin
    bus.req_ready  = (state == IDLE);
    bus.resp_valid = (state == RESP);
    bus.mem_read   = (state == READ);
    bus.mem_write  = (state == WRITE);
    busy           = (state != IDLE);
  end

  assign bus.mem_address = addr_q;
  assign bus.mem_wdata   = wdata_q;
  assign bus.resp_rdata  = rdata_q;
  assign bus.resp_err    = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      load_count  <= '0;
      store_count <= '0;
      err_count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            rdata_q <= '0;
            err_q   <= out_of_range;
            if (out_of_range && (err_count != '1))
              err_count <= err_count + 1'b1;
          end
        end
        READ: begin
          rdata_q    <= bus.mem_rdata;
          load_count <= load_count + 1'b1;
        end
        WRITE:   store_count <= store_count + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit with a behavioural data memory,
// a vector table for single requests and hand sequences for stall and reset.
module tb_mem_access_unit;

  logic        clk;
  logic        rst_n;
  logic        busy;
  logic [15:0] load_count, store_count, err_count;
  logic [15:0] mem [0:255];

  int tests  = 0;
  int failed = 0;

  mem_access_unit_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  mem_access_unit #(
    .ADDR_W(16), .DATA_W(16), .MEM_DEPTH(256), .CNT_W(16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .busy        (busy),
    .load_count  (load_count),
    .store_count (store_count),
    .err_count   (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory: combinational read, write at the closing edge of the strobe.
  assign bus.mem_rdata = bus.mem_read ? mem[bus.mem_address[7:0]] : 16'h0000;
  always @(posedge clk) if (bus.mem_write) mem[bus.mem_address[7:0]] <= bus.mem_wdata;

  typedef struct {
    logic        store;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [15:0] rdata;
    logic        err;
    int          rd;
    int          wr;
  } exp_t;

  exp_t sbq[$];
  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic store, input logic [15:0] addr,
                               input logic [15:0] wdata, input logic [15:0] exp_rdata,
                               input logic exp_err);
    exp_t e;
    int   guard = 0;
    @(negedge clk);
    while (!bus.req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) check("req_ready_timeout", 32'd1, 32'd0);
    bus.req_valid = 1'b1;
    bus.req_store = store;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.rd    = (!exp_err && !store) ? 1 : 0;
    e.wr    = (!exp_err && store) ? 1 : 0;
    sbq.push_back(e);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  task automatic checkOutput(input string name);
    exp_t e;
    int lat = 1;
    int rd = 0;
    int wr = 0;
    forever begin
      @(negedge clk);
      if (bus.resp_valid || lat >= 20) break;
      if (bus.mem_read)  rd++;
      if (bus.mem_write) wr++;
      if (bus.mem_read && bus.mem_write) check({name, "_both_strobes"}, 32'd1, 32'd0);
      @(posedge clk);
      lat++;
    end
    if (lat >= 20) begin
      check({name, "_resp_timeout"}, 32'd1, 32'd0);
      return;
    end
    if (sbq.size() == 0) begin
      check({name, "_scoreboard_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sbq.pop_front();
    check({name, "_rdata"},   32'(bus.resp_rdata), 32'(e.rdata));
    check({name, "_err"},     32'(bus.resp_err),   32'(e.err));
    check({name, "_rd_cyc"},  32'(rd),             32'(e.rd));
    check({name, "_wr_cyc"},  32'(wr),             32'(e.wr));
    check({name, "_latency"}, 32'(lat),            e.err ? 32'd1 : 32'd2);
    if (bus.resp_ready) @(posedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[0] = 16'h0253;
    mem[1] = 16'h2022;

    vecs[0] = '{1'b0, 16'h0000, 16'h0000, 16'h0253, 1'b0};
    vecs[1] = '{1'b0, 16'h0001, 16'h0000, 16'h2022, 1'b0};
    vecs[2] = '{1'b1, 16'h0010, 16'h00A5, 16'h0000, 1'b0};
    vecs[3] = '{1'b0, 16'h0010, 16'h0000, 16'h00A5, 1'b0};
    vecs[4] = '{1'b0, 16'h0100, 16'h0000, 16'h0000, 1'b1};
    vecs[5] = '{1'b1, 16'h00FF, 16'hBEEF, 16'h0000, 1'b0};
    vecs[6] = '{1'b0, 16'h00FF, 16'h0000, 16'hBEEF, 1'b0};
    vecs[7] = '{1'b1, 16'h0100, 16'h5555, 16'h0000, 1'b1};
    vecs[8] = '{1'b0, 16'hFFFF, 16'h0000, 16'h0000, 1'b1};

    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_store  = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_req_ready",  32'(bus.req_ready),  32'd1);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_busy",       32'(busy),           32'd0);
    check("rst_strobes",    32'({bus.mem_read, bus.mem_write}), 32'd0);
    check("rst_counters",   {load_count, store_count} | 32'(err_count), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].store, vecs[i].addr, vecs[i].wdata,
                    vecs[i].exp_rdata, vecs[i].exp_err);
      checkOutput($sformatf("vec%0d", i));
    end
    #1;
    check("load_count",  32'(load_count),  32'd4);
    check("store_count", 32'(store_count), 32'd2);
    check("err_count",   32'(err_count),   32'd3);

    // Response stalled for three cycles while a competing request is offered.
    bus.resp_ready = 1'b0;
    applyStimulus(1'b0, 16'h0001, 16'h0000, 16'h2022, 1'b0);
    begin
      int guard = 0;
      @(negedge clk);
      while (!bus.resp_valid && guard < 20) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 20) check("stall_resp_timeout", 32'd1, 32'd0);
    end
    for (int c = 0; c < 3; c++) begin
      bus.req_valid = 1'b1;
      bus.req_store = 1'b1;
      bus.req_addr  = 16'h0030;
      bus.req_wdata = 16'h7777;
      check("stall_resp_valid", 32'(bus.resp_valid), 32'd1);
      check("stall_rdata",      32'(bus.resp_rdata), 32'h2022);
      check("stall_req_ready",  32'(bus.req_ready),  32'd0);
      check("stall_mem_write",  32'(bus.mem_write),  32'd0);
      @(negedge clk);
    end
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    if (sbq.size() != 0) begin
      exp_t e;
      e = sbq.pop_front();
      check("stall_final_rdata", 32'(bus.resp_rdata), 32'(e.rdata));
    end else check("stall_scoreboard_empty", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    check("stall_idle",        32'(bus.req_ready), 32'd1);
    check("stall_load_count",  32'(load_count),    32'd5);
    check("stall_store_count", 32'(store_count),   32'd2);
    applyStimulus(1'b0, 16'h0030, 16'h0000, 16'h0000, 1'b0);
    checkOutput("stall_no_accept");

    // Reset lands while the write strobe is up; nothing may be written.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_store = 1'b1;
    bus.req_addr  = 16'h0020;
    bus.req_wdata = 16'h1234;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    check("abort_write_strobe", 32'(bus.mem_write), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_mem_write",  32'(bus.mem_write),  32'd0);
    check("abort_req_ready",  32'(bus.req_ready),  32'd1);
    check("abort_busy",       32'(busy),           32'd0);
    check("abort_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("abort_counters",   {load_count, store_count} | 32'(err_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 16'h0020, 16'h0000, 16'h0000, 1'b0);
    checkOutput("abort_readback");
    #1;
    check("abort_load_count", 32'(load_count), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
